// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine.
package gcd_pkg;

    localparam int unsigned GCD_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COMPUTE = 2'b01,
        S_DONE    = 2'b10
    } state_e;

endpackage

// File: rtl/gcd_datapath.sv
// Subtract-based Euclid datapath: operand registers, compare/subtract and result latch.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GCD_DEFAULT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic                  latch_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  done_cond_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    logic [DATA_WIDTH-1:0] a_q, b_q, result_q;
    logic                  a_zero, b_zero, a_gt_b;

    assign a_zero      = (a_q == '0);
    assign b_zero      = (b_q == '0);
    assign a_gt_b      = (a_q > b_q);
    assign done_cond_o = a_zero | b_zero | (a_q == b_q);
    assign result_o    = result_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            if (load_i) begin
                a_q <= a_i;
                b_q <= b_i;
            end else if (step_i) begin
                // Comparison guard keeps both subtractions non-negative.
                if (a_gt_b) begin
                    a_q <= a_q - b_q;
                end else begin
                    b_q <= b_q - a_q;
                end
            end
            if (latch_i) begin
                result_q <= a_zero ? b_q : a_q;
            end
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine top: control FSM, valid/ready handshakes and abort.
// Define GCD_ENGINE_CYCLE_COUNT_EN to add the cycles_o compute-cycle counter.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GCD_DEFAULT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  abort_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] gcd_o,
    output logic                  busy_o,
    output logic [1:0]            state_o
`ifdef GCD_ENGINE_CYCLE_COUNT_EN
    ,
    output logic [DATA_WIDTH-1:0] cycles_o
`endif
);

    state_e state_q, state_d;
    logic   load, step, latch, done_cond;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        latch   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    load    = 1'b1;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                // Abort wins over completion, so no result is latched.
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (done_cond) begin
                    latch   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            S_DONE: begin
                if (abort_i || out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign busy_o      = (state_q == S_COMPUTE);
    assign out_valid_o = (state_q == S_DONE);
    assign state_o     = state_q;

    gcd_datapath #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_datapath (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (load),
        .step_i     (step),
        .latch_i    (latch),
        .a_i        (a_i),
        .b_i        (b_i),
        .done_cond_o(done_cond),
        .result_o   (gcd_o)
    );

`ifdef GCD_ENGINE_CYCLE_COUNT_EN
    logic [DATA_WIDTH-1:0] cycles_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycles_q <= '0;
        end else if (load) begin
            cycles_q <= '0;
        end else if (state_q == S_COMPUTE) begin
            cycles_q <= cycles_q + 1'b1;
        end
    end

    assign cycles_o = cycles_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine against a Euclid-division reference model.
module tb_gcd_engine;

    localparam int W = 8;
    localparam int BUDGET = 600;

    logic         clk = 1'b0;
    logic         reset_i, in_valid_i, abort_i, out_ready_i;
    logic [W-1:0] a_i, b_i;
    logic         in_ready_o, out_valid_o, busy_o;
    logic [W-1:0] gcd_o;
    logic [1:0]   state_o;
`ifdef GCD_ENGINE_CYCLE_COUNT_EN
    logic [W-1:0] cycles_o;
`endif

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    gcd_engine #(
        .DATA_WIDTH(W)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .abort_i    (abort_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .gcd_o      (gcd_o),
        .busy_o     (busy_o),
        .state_o    (state_o)
`ifdef GCD_ENGINE_CYCLE_COUNT_EN
        ,
        .cycles_o   (cycles_o)
`endif
    );

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtraction steps = sum of Euclid quotients, minus the final one saved by the A==B stop.
    function automatic int ref_steps(input int a, input int b);
        int s, t;
        if (a == 0 || b == 0) return 0;
        s = 0;
        while (b != 0) begin
            s = s + a / b;
            t = a % b;
            a = b;
            b = t;
        end
        return s - 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake a job, then count edges until out_valid_o and compute cycles seen on busy_o.
    task automatic do_job(input int a, input int b, output int lat, output int busy_cnt,
                          output logic [W-1:0] res);
        int guard = 0;
        while (!in_ready_o && guard < BUDGET) begin
            tick();
            guard++;
        end
        a_i        = W'(a);
        b_i        = W'(b);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        lat        = 0;
        busy_cnt   = 0;
        while (!out_valid_o && lat < BUDGET) begin
            if (busy_o) busy_cnt++;
            tick();
            lat++;
        end
        res = gcd_o;
    endtask

    task automatic test_reset();
        reset_i     = 1'b1;
        in_valid_i  = 1'b0;
        abort_i     = 1'b0;
        out_ready_i = 1'b1;
        a_i         = '0;
        b_i         = '0;
        tick();
        tick();
        reset_i = 1'b0;
        total++;
        if ({state_o, in_ready_o, out_valid_o, busy_o, gcd_o} !== {2'b00, 3'b100, 8'h00})
            $display("FAIL reset: state=%b rdy=%b vld=%b busy=%b gcd=%0d, expected 00 1 0 0 0",
                     state_o, in_ready_o, out_valid_o, busy_o, gcd_o);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        int pa[5] = '{12, 0, 0, 5, 255};
        int pb[5] = '{8, 9, 0, 5, 1};
        int lat, bc, exp_lat;
        logic [W-1:0] res;
        for (int i = 0; i < 5; i++) begin
            do_job(pa[i], pb[i], lat, bc, res);
            exp_lat = ref_steps(pa[i], pb[i]) + 1;
            total++;
            if (res !== W'(ref_gcd(pa[i], pb[i])))
                $display("FAIL directed_gcd(%0d,%0d): got %0d expected %0d",
                         pa[i], pb[i], res, ref_gcd(pa[i], pb[i]));
            else pass_cnt++;
            total++;
            if (lat != exp_lat || bc != exp_lat)
                $display("FAIL directed_latency(%0d,%0d): lat=%0d busy=%0d expected %0d",
                         pa[i], pb[i], lat, bc, exp_lat);
            else pass_cnt++;
`ifdef GCD_ENGINE_CYCLE_COUNT_EN
            total++;
            if (cycles_o !== W'(exp_lat))
                $display("FAIL directed_cycles(%0d,%0d): got %0d expected %0d",
                         pa[i], pb[i], cycles_o, exp_lat);
            else pass_cnt++;
`endif
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat, bc;
        logic [W-1:0] res;
        int bad = 0;
        out_ready_i = 1'b0;
        do_job(36, 24, lat, bc, res);
        in_valid_i = 1'b1;
        a_i = 8'd9;
        b_i = 8'd6;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid_o || gcd_o !== 8'd12 || in_ready_o) bad++;
            tick();
        end
        total++;
        if (bad != 0)
            $display("FAIL backpressure_hold: %0d bad cycles (vld=%b gcd=%0d rdy=%b), expected 0",
                     bad, out_valid_o, gcd_o, in_ready_o);
        else pass_cnt++;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        total++;
        if (state_o !== 2'b00 || out_valid_o !== 1'b0 || gcd_o !== 8'd12)
            $display("FAIL backpressure_release: state=%b vld=%b gcd=%0d, expected 00 0 12",
                     state_o, out_valid_o, gcd_o);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int lat, bc;
        logic [W-1:0] res;
        int seen = 0;
        a_i = 8'd200;
        b_i = 8'd3;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        total++;
        if (state_o !== 2'b00 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1)
            $display("FAIL abort_state: state=%b vld=%b rdy=%b, expected 00 0 1",
                     state_o, out_valid_o, in_ready_o);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            if (out_valid_o) seen++;
            tick();
        end
        total++;
        if (seen != 0) $display("FAIL abort_no_result: out_valid seen %0d times, expected 0", seen);
        else pass_cnt++;
        do_job(21, 14, lat, bc, res);
        total++;
        if (res !== 8'd7) $display("FAIL abort_next_job: got %0d expected 7", res);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        a_i = 8'd100;
        b_i = 8'd7;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        total++;
        if ({state_o, out_valid_o, gcd_o, in_ready_o, busy_o} !== {2'b00, 1'b0, 8'h00, 2'b10})
            $display("FAIL reset_mid: state=%b vld=%b gcd=%0d rdy=%b busy=%b, expected 00 0 0 1 0",
                     state_o, out_valid_o, gcd_o, in_ready_o, busy_o);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int a, b, lat, bc, exp_lat;
        logic [W-1:0] res;
        for (int i = 0; i < 25; i++) begin
            a = (i % 5 == 0) ? 0 : int'($urandom_range(1, 255));
            b = (i % 7 == 3) ? a : int'($urandom_range(0, 255));
            do_job(a, b, lat, bc, res);
            exp_lat = ref_steps(a, b) + 1;
            total++;
            if (res !== W'(ref_gcd(a, b)) || lat != exp_lat || bc != exp_lat)
                $display("FAIL random(%0d,%0d): gcd=%0d lat=%0d busy=%0d expected gcd=%0d lat=%0d",
                         a, b, res, lat, bc, ref_gcd(a, b), exp_lat);
            else pass_cnt++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
